load_ext_ctrl: RTL and testbench

Load-unit controller between the RV32I execute stage and the data-memory port. Accepts one load request (address + funct3), sequences one or two word-aligned memory reads over a req/ack handshake, then selects the addressed byte/halfword/word and sign- or zero-extends it to 32 bits. Misaligned halfword/word loads that cross a word boundary are split into two accesses. Misaligned loads can be rejected instead when SPLIT_EN=0.

---
 rtl/load_ext_ctrl.sv | 139 +++++++++++++
 tb/tb_load_ext_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_ext_ctrl.sv
// RV32I load-unit controller: one or two word reads over a req/ack port, then
// byte/halfword/word selection with sign or zero extension.
module load_ext_ctrl #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [1:0]  fsm_state
);

    // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
    // a memory read completes on a rising edge where mem_req && mem_ack, and
    // mem_req/mem_addr hold steady until then; rsp_valid is a one-cycle strobe
    // with no backpressure.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
    localparam logic [1:0] ACC1 = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        err_q;
    logic        cross_q;
    logic [31:0] lo_q;
    logic [23:0] hi_q;

    logic        f3_legal;
    logic        req_cross;
    logic [31:0] win_word;
    logic [31:0] ext_data;

    assign req_ready = (state == IDLE);
    assign fsm_state = state;

    always_comb begin
        f3_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
        endcase
        req_cross = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                    ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    end

    // Only the low three bytes of the second word can ever reach the result.
    always_comb begin
        win_word = lo_q;
        case (off_q)
            2'd0:    win_word = lo_q;
            2'd1:    win_word = {hi_q[7:0],  lo_q[31:8]};
            2'd2:    win_word = {hi_q[15:0], lo_q[31:16]};
            default: win_word = {hi_q[23:0], lo_q[31:24]};
        endcase
        ext_data = win_word;
        case (funct3_q)
            3'b000:  ext_data = {{24{win_word[7]}},  win_word[7:0]};
            3'b001:  ext_data = {{16{win_word[15]}}, win_word[15:0]};
            3'b100:  ext_data = {24'd0, win_word[7:0]};
            3'b101:  ext_data = {16'd0, win_word[15:0]};
            default: ext_data = win_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 32'd0;
            off_q     <= 2'd0;
            funct3_q  <= 3'd0;
            err_q     <= 1'b0;
            cross_q   <= 1'b0;
            lo_q      <= 32'd0;
            hi_q      <= 24'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q    <= req_addr[1:0];
                        funct3_q <= req_funct3;
                        cross_q  <= req_cross;
                        hi_q     <= 24'd0;
                        if (!f3_legal || (req_cross && !SPLIT_EN)) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q    <= 1'b0;
                            mem_req  <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                            state    <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    if (mem_req && mem_ack) begin
                        lo_q <= mem_rdata;
                        if (cross_q) begin
                            mem_addr <= mem_addr + 32'd4;
                            state    <= ACC1;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= RESP;
                        end
                    end
                end
                ACC1: begin
                    if (mem_req && mem_ack) begin
                        hi_q    <= mem_rdata[23:0];
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_data  <= err_q ? 32'd0 : ext_data;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Directed bench for load_ext_ctrl: a split-enabled instance does the main work,
// a split-disabled instance covers misaligned rejection.
module tb_load_ext_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  fsm_state;

    logic        ns_req_valid;
    logic        ns_req_ready;
    logic        ns_mem_req;
    logic [31:0] ns_mem_addr;
    logic        ns_mem_ack;
    logic        ns_rsp_valid;
    logic [31:0] ns_rsp_data;
    logic        ns_rsp_err;
    logic [1:0]  ns_fsm_state;

    int passed;
    int total;

    load_ext_ctrl #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fsm_state(fsm_state)
    );

    load_ext_ctrl #(.SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .req_valid(ns_req_valid), .req_ready(ns_req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_req(ns_mem_req),
        .mem_addr(ns_mem_addr), .mem_ack(ns_mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(ns_rsp_valid), .rsp_data(ns_rsp_data), .rsp_err(ns_rsp_err),
        .fsm_state(ns_fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h80F1_7F01;
            32'h0000_0104: return 32'h1234_5678;
            32'hFFFF_FFFC: return 32'hAB00_0000;
            32'h0000_0000: return 32'h0000_00CD;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // driver: issue one load, serve memory with 'delay' wait cycles per access,
    // and record what the DUT did
    task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input int delay,
                           input bit hold, output logic [31:0] data, output logic err,
                           output int lat, output int nrsp, output int nacc,
                           output logic [31:0] a0, output logic [31:0] a1,
                           output int unstable);
        bit          prev_req;
        bit          prev_acked;
        logic [31:0] prev_addr;
        int          w;
        data = 'x; err = 'x; lat = -1; nrsp = 0; nacc = 0;
        a0 = 'x; a1 = 'x; unstable = 0;
        prev_req = 0; prev_acked = 0; prev_addr = '0; w = 0;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_funct3 = f3;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!hold || req_ready) req_valid = 1'b0;
            if (rsp_valid) begin
                nrsp++;
                if (lat < 0) begin
                    lat = k; data = rsp_data; err = rsp_err;
                end
            end
            if (mem_req) begin
                if (!prev_req || prev_acked) begin
                    if (nacc == 0) a0 = mem_addr; else a1 = mem_addr;
                    nacc++;
                    w = 0;
                end else if (mem_addr !== prev_addr) begin
                    unstable++;
                end
                if (w == delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                end
                w++;
            end
            prev_req = mem_req; prev_addr = mem_addr; prev_acked = mem_ack;
            if (lat >= 0 && k >= lat + 2) break;
            @(posedge clk);
        end
        mem_ack = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_req); else passed++;
        total++; if (mem_addr !== 32'd0) $display("FAIL reset_mem_addr got %h exp 0", mem_addr); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else passed++;
        total++; if ({rsp_err, rsp_data} !== 33'd0) $display("FAIL reset_rsp got err=%b data=%h exp 0/0", rsp_err, rsp_data); else passed++;
        total++; if (fsm_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", fsm_state); else passed++;
    endtask

    task automatic test_byte_loads();
        logic [31:0] d, a0, a1;
        logic e;
        int lat, nrsp, nacc, uns;
        logic [31:0] addrs[3] = '{32'h101, 32'h102, 32'h102};
        logic [2:0]  f3s[3]   = '{3'b000, 3'b000, 3'b100};
        logic [31:0] exps[3]  = '{32'h0000_007F, 32'hFFFF_FFF1, 32'h0000_00F1};
        for (int i = 0; i < 3; i++) begin
            do_load(addrs[i], f3s[i], 0, 0, d, e, lat, nrsp, nacc, a0, a1, uns);
            total++; if (d !== exps[i] || e !== 1'b0) $display("FAIL byte_%0d data got %h err=%b exp %h err=0", i, d, e, exps[i]); else passed++;
            total++; if (nacc !== 1 || a0 !== 32'h100) $display("FAIL byte_%0d_access got n=%0d addr=%h exp n=1 addr=00000100", i, nacc, a0); else passed++;
        end
    endtask

    task automatic test_aligned_latency();
        logic [31:0] d, a0, a1;
        logic e;
        int lat, nrsp, nacc, uns;
        logic [31:0] addrs[3] = '{32'h102, 32'h102, 32'h100};
        logic [2:0]  f3s[3]   = '{3'b001, 3'b101, 3'b010};
        logic [31:0] exps[3]  = '{32'hFFFF_80F1, 32'h0000_80F1, 32'h80F1_7F01};
        for (int i = 0; i < 3; i++) begin
            do_load(addrs[i], f3s[i], 0, 0, d, e, lat, nrsp, nacc, a0, a1, uns);
            total++; if (d !== exps[i] || e !== 1'b0) $display("FAIL hw_%0d data got %h err=%b exp %h err=0", i, d, e, exps[i]); else passed++;
            total++; if (lat !== 2) $display("FAIL hw_%0d_latency got %0d exp 2", i, lat); else passed++;
        end
    endtask

    task automatic test_split();
        logic [31:0] d, a0, a1;
        logic e;
        int lat, nrsp, nacc, uns;
        logic [31:0] addrs[3] = '{32'h103, 32'h101, 32'hFFFF_FFFF};
        logic [2:0]  f3s[3]   = '{3'b001, 3'b010, 3'b001};
        logic [31:0] exps[3]  = '{32'h0000_7880, 32'h7880_F17F, 32'hFFFF_CDAB};
        logic [31:0] e0[3]    = '{32'h100, 32'h100, 32'hFFFF_FFFC};
        logic [31:0] e1[3]    = '{32'h104, 32'h104, 32'h0};
        for (int i = 0; i < 3; i++) begin
            do_load(addrs[i], f3s[i], 0, 0, d, e, lat, nrsp, nacc, a0, a1, uns);
            total++; if (d !== exps[i] || e !== 1'b0) $display("FAIL split_%0d data got %h err=%b exp %h err=0", i, d, e, exps[i]); else passed++;
            total++; if (nacc !== 2 || a0 !== e0[i] || a1 !== e1[i])
                $display("FAIL split_%0d_addrs got n=%0d %h %h exp n=2 %h %h", i, nacc, a0, a1, e0[i], e1[i]); else passed++;
        end
    endtask

    task automatic test_reject();
        int lat;
        int nreq;
        lat = -1; nreq = 0;
        @(negedge clk);
        ns_req_valid = 1'b1; req_addr = 32'h101; req_funct3 = 3'b010;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ns_req_valid = 1'b0;
            if (ns_mem_req) nreq++;
            if (ns_rsp_valid && lat < 0) begin
                lat = k;
                total++; if (ns_rsp_err !== 1'b1 || ns_rsp_data !== 32'd0)
                    $display("FAIL reject_rsp got err=%b data=%h exp err=1 data=0", ns_rsp_err, ns_rsp_data); else passed++;
            end
            if (k < 4) @(posedge clk);
        end
        total++; if (lat !== 1) $display("FAIL reject_latency got %0d exp 1", lat); else passed++;
        total++; if (nreq !== 0) $display("FAIL reject_mem_req got %0d cycles exp 0", nreq); else passed++;
    endtask

    task automatic test_illegal();
        logic [31:0] d, a0, a1;
        logic e;
        int lat, nrsp, nacc, uns;
        logic [2:0] f3s[2] = '{3'b011, 3'b111};
        for (int i = 0; i < 2; i++) begin
            do_load(32'h100, f3s[i], 0, 1, d, e, lat, nrsp, nacc, a0, a1, uns);
            total++; if (e !== 1'b1 || d !== 32'd0) $display("FAIL illegal_%0d_rsp got err=%b data=%h exp err=1 data=0", i, e, d); else passed++;
            total++; if (lat !== 1 || nrsp !== 1 || nacc !== 0)
                $display("FAIL illegal_%0d_timing got lat=%0d nrsp=%0d nacc=%0d exp 1/1/0", i, lat, nrsp, nacc); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, a0, a1;
        logic e;
        int lat, nrsp, nacc, uns;
        do_load(32'h100, 3'b010, 0, 1, d, e, lat, nrsp, nacc, a0, a1, uns);
        total++; if (d !== 32'h80F1_7F01 || nrsp !== 1 || nacc !== 1)
            $display("FAIL busy_hold got data=%h nrsp=%0d nacc=%0d exp 80f17f01/1/1", d, nrsp, nacc); else passed++;
        @(negedge clk);
        total++; if (rsp_data !== 32'h80F1_7F01 || rsp_valid !== 1'b0)
            $display("FAIL rsp_hold got data=%h valid=%b exp 80f17f01/0", rsp_data, rsp_valid); else passed++;
        do_load(32'h104, 3'b000, 0, 0, d, e, lat, nrsp, nacc, a0, a1, uns);
        total++; if (d !== 32'h0000_0078 || e !== 1'b0) $display("FAIL next_lb got %h err=%b exp 00000078 err=0", d, e); else passed++;
    endtask

    task automatic test_wait_states();
        logic [31:0] d, a0, a1;
        logic e;
        int lat, nrsp, nacc, uns;
        do_load(32'h102, 3'b010, 3, 0, d, e, lat, nrsp, nacc, a0, a1, uns);
        total++; if (d !== 32'h5678_80F1 || e !== 1'b0) $display("FAIL wait_data got %h err=%b exp 567880f1 err=0", d, e); else passed++;
        total++; if (nrsp !== 1) $display("FAIL wait_nrsp got %0d exp 1", nrsp); else passed++;
        total++; if (uns !== 0 || nacc !== 2 || a0 !== 32'h100 || a1 !== 32'h104)
            $display("FAIL wait_addr got unstable=%0d n=%0d %h %h exp 0/2/100/104", uns, nacc, a0, a1); else passed++;
        total++; if (lat !== 9) $display("FAIL wait_latency got %0d exp 9", lat); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, a0, a1;
        logic e;
        int lat, nrsp, nacc, uns;
        int stray;
        stray = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h101; req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = mem_word(mem_addr);
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) $display("FAIL mid_acc1 got req=%b addr=%h exp 1/00000104", mem_req, mem_addr); else passed++;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (mem_req !== 1'b0 || req_ready !== 1'b1) $display("FAIL mid_reset got mem_req=%b req_ready=%b exp 0/1", mem_req, req_ready); else passed++;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) stray++;
            @(negedge clk);
        end
        total++; if (stray !== 0) $display("FAIL mid_late_ack got %0d strobes exp 0", stray); else passed++;
        do_load(32'h100, 3'b000, 0, 0, d, e, lat, nrsp, nacc, a0, a1, uns);
        total++; if (d !== 32'h0000_0001 || e !== 1'b0) $display("FAIL mid_recover got %h err=%b exp 00000001 err=0", d, e); else passed++;
    endtask

    initial begin
        passed = 0; total = 0;
        rst_n = 1'b0; req_valid = 1'b0; ns_req_valid = 1'b0;
        req_addr = '0; req_funct3 = '0;
        mem_ack = 1'b0; ns_mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_byte_loads();
        test_aligned_latency();
        test_split();
        test_reject();
        test_illegal();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
